div_result_uart_tx: RTL and testbench

Serial result transmitter for the divider path. It captures the 16-bit quotient and remainder on the divider's completion pulse and sends them over a UART TX line as 8N1 frames, so a host PC can read results. The divider consumes operands and emits `done`/`shang`/`yushu`; this block consumes those outputs and drives the board's UART TX pin.

---
 rtl/div_result_uart_tx_if.sv | 28 ++
 rtl/div_result_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_div_result_uart_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_result_uart_tx_if.sv
// Result-transmitter bus: divider result inputs and UART-side outputs.
// master = divider/host side, slave = div_result_uart_tx.
interface div_result_uart_tx_if;
  logic        done;
  logic [15:0] shang;
  logic [15:0] yushu;
  logic        tx;
  logic        busy;
  logic        overrun;

  modport master (
    output done,
    output shang,
    output yushu,
    input  tx,
    input  busy,
    input  overrun
  );

  modport slave (
    input  done,
    input  shang,
    input  yushu,
    output tx,
    output busy,
    output overrun
  );
endinterface

// File: rtl/div_result_uart_tx.sv
// Sends the divider's quotient/remainder as 8N1 UART frames on each rising edge of done.
// Define DIV_TX_ASCII_HEX_EN for a 10-byte ASCII hex line instead of 4 raw bytes.
module div_result_uart_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  div_result_uart_tx_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CLKS_PER_BIT - 1);

`ifdef DIV_TX_ASCII_HEX_EN
  localparam logic [3:0] LAST_BYTE = 4'd9;
`else
  localparam logic [3:0] LAST_BYTE = 4'd3;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [31:0]      hold_q, hold_d;
  logic             done_q;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             cap_evt;
  logic             cnt_term;
  logic [7:0]       cur_byte;

`ifdef DIV_TX_ASCII_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = 8'h30 + {4'h0, n};
    else           r = 8'h37 + {4'h0, n};
    return r;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] h, input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = hex_ascii(h[31:28]);
      4'd1:    r = hex_ascii(h[27:24]);
      4'd2:    r = hex_ascii(h[23:20]);
      4'd3:    r = hex_ascii(h[19:16]);
      4'd4:    r = hex_ascii(h[15:12]);
      4'd5:    r = hex_ascii(h[11:8]);
      4'd6:    r = hex_ascii(h[7:4]);
      4'd7:    r = hex_ascii(h[3:0]);
      4'd8:    r = 8'h0D;
      4'd9:    r = 8'h0A;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction
`else
  function automatic logic [7:0] byte_sel(input logic [31:0] h, input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = h[31:24];
      4'd1:    r = h[23:16];
      4'd2:    r = h[15:8];
      4'd3:    r = h[7:0];
      default: r = 8'hFF;
    endcase
    return r;
  endfunction
`endif

  assign cap_evt  = bus.done & ~done_q;
  assign cnt_term = (cnt_q == CNT_TERM);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      hold_q    <= hold_d;
      done_q    <= bus.done;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    hold_d    = hold_q;
    // Any non-IDLE state counts as busy, including the cycle the last stop bit ends.
    overrun_d = cap_evt && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cap_evt) begin
          hold_d  = {bus.shang, bus.yushu};
          byte_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_term) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_term) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_term) begin
          cnt_d = '0;
          if (byte_q == LAST_BYTE) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line level is registered from next-state values so the pin never glitches.
  always_comb begin
    cur_byte = byte_sel(hold_d, byte_d);
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_div_result_uart_tx.sv
// Self-checking bench for div_result_uart_tx: randomized and directed results
// compared against a byte-list model decoded by a mid-bit UART monitor.
module tb_div_result_uart_tx;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
`ifdef DIV_TX_ASCII_HEX_EN
  localparam int unsigned NB = 10;
`else
  localparam int unsigned NB = 4;
`endif

  logic clk;
  logic rst;
  div_result_uart_tx_if bus();

  div_result_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok_q[$];
  int         busy_cyc = 0;
  int         ov_cyc   = 0;
  int         ov_rise  = 0;
  logic       ov_prev  = 1'b0;

  // UART receiver: detect start, sample every bit at its midpoint.
  initial begin
    logic [7:0] b;
    bit         sok;
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        sok = (bus.tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        sok = sok && (bus.tx === 1'b1);
        rx_q.push_back(b);
        rx_ok_q.push_back(sok);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cyc++;
    if (bus.overrun === 1'b1) begin
      ov_cyc++;
      if (ov_prev !== 1'b1) ov_rise++;
    end
    ov_prev = bus.overrun;
  end

  function automatic void model(input logic [15:0] s, input logic [15:0] y,
                                output logic [7:0] e[10]);
    int unsigned v;
    int unsigned nib;
    for (int i = 0; i < 10; i++) e[i] = 8'h00;
`ifdef DIV_TX_ASCII_HEX_EN
    v = (int'(s) << 16) | int'(y);
    for (int i = 0; i < 8; i++) begin
      nib  = (v >> (28 - 4 * i)) & 15;
      e[i] = (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
    end
    e[8] = 8'h0D;
    e[9] = 8'h0A;
`else
    e[0] = 8'(s / 256);
    e[1] = 8'(s % 256);
    e[2] = 8'(y / 256);
    e[3] = 8'(y % 256);
`endif
  endfunction

  task automatic wait_idle(input string name);
    bit seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: busy still %b after 3000 cycles, required 0", name, bus.busy);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_bytes(input string name, input int base, input logic [7:0] e[10]);
    n_cmp++;
    if (rx_q.size() - base != NB) begin
      n_err++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, rx_q.size() - base, NB);
    end
    for (int i = 0; i < NB; i++) begin
      if (base + i < rx_q.size()) begin
        n_cmp++;
        if (rx_q[base + i] !== e[i] || !rx_ok_q[base + i]) begin
          n_err++;
          $display("FAIL %s_byte%0d: got %h framing_ok=%0d, required %h framing_ok=1",
                   name, i, rx_q[base + i], rx_ok_q[base + i], e[i]);
        end
      end
    end
  endtask

  task automatic send_and_check(input logic [15:0] s, input logic [15:0] y, input string name);
    logic [7:0] e[10];
    int base, b0;
    model(s, y, e);
    base = rx_q.size();
    b0   = busy_cyc;
    @(posedge clk); #1;
    bus.done = 1'b1; bus.shang = s; bus.yushu = y;
    n_cmp++;
    if (bus.tx !== 1'b1) begin
      n_err++; $display("FAIL %s_pre_tx: got %b, required 1", name, bus.tx);
    end
    @(posedge clk); #1;
    bus.done = 1'b0; bus.shang = 16'($urandom); bus.yushu = 16'($urandom);
    n_cmp++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: tx=%b busy=%b one cycle after done, required tx=0 busy=1",
               name, bus.tx, bus.busy);
    end
    wait_idle(name);
    n_cmp++;
    if (busy_cyc - b0 != int'(NB * 10 * CPB)) begin
      n_err++;
      $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, busy_cyc - b0, NB * 10 * CPB);
    end
    check_bytes(name, base, e);
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1; bus.done = 1'b0; bus.shang = '0; bus.yushu = '0;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (bus.tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b, required 1", bus.tx); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    n_cmp++;
    if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b, required 0", bus.overrun); end
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL idle_quiet: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_directed();
    send_and_check(16'h1234, 16'h0056, "dir_1234");
    send_and_check(16'hBEEF, 16'h000A, "dir_beef");
    send_and_check(16'h0000, 16'hFFFF, "dir_edge");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      send_and_check(16'($urandom), 16'($urandom), $sformatf("rand%0d", k));
  endtask

  task automatic test_overrun();
    logic [7:0] e[10];
    logic [15:0] s, y;
    int base, oc0, or0;
    s = 16'($urandom); y = 16'($urandom);
    model(s, y, e);
    base = rx_q.size(); oc0 = ov_cyc; or0 = ov_rise;
    @(posedge clk); #1; bus.done = 1'b1; bus.shang = s; bus.yushu = y;
    @(posedge clk); #1; bus.done = 1'b0;
    repeat (49) @(posedge clk);
    #1; bus.done = 1'b1; bus.shang = 16'hFFFF; bus.yushu = 16'($urandom);
    @(posedge clk); #1; bus.done = 1'b0;
    wait_idle("overrun");
    n_cmp++;
    if (ov_rise - or0 != 1 || ov_cyc - oc0 != 1) begin
      n_err++;
      $display("FAIL overrun_pulse: pulses=%0d high_cycles=%0d, required 1 and 1",
               ov_rise - or0, ov_cyc - oc0);
    end
    check_bytes("overrun", base, e);
  endtask

  task automatic test_done_held();
    logic [7:0] e[10];
    logic [15:0] s, y;
    int base, oc0;
    s = 16'($urandom); y = 16'($urandom);
    model(s, y, e);
    base = rx_q.size(); oc0 = ov_cyc;
    @(posedge clk); #1; bus.done = 1'b1; bus.shang = s; bus.yushu = y;
    @(posedge clk); #1; bus.shang = 16'($urandom); bus.yushu = 16'($urandom);
    repeat (999) @(posedge clk);
    #1; bus.done = 1'b0;
    wait_idle("held");
    n_cmp++;
    if (ov_cyc - oc0 != 0) begin
      n_err++; $display("FAIL held_overrun: got %0d cycles, required 0", ov_cyc - oc0);
    end
    check_bytes("held", base, e);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1; bus.done = 1'b1; bus.shang = 16'($urandom); bus.yushu = 16'($urandom);
    @(posedge clk); #1; bus.done = 1'b0;
    repeat (2 * 10 * CPB + 3 * CPB) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_state: tx=%b busy=%b, required tx=1 busy=0", bus.tx, bus.busy);
    end
    repeat (12 * CPB) @(posedge clk);
    send_and_check(16'($urandom), 16'($urandom), "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_done_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
